// File: rtl/alu_pkg.sv
// Shared ALU constants: op encodings, pipeline depth and operand helpers.
// Imported by the add/sub pipeline and its testbench.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  localparam int ADDSUB_LAT = 3;

  // SUB/SBB add the one's complement of b
  function automatic logic op_inv(op_e o);
    logic r;
    r = 1'b0;
    unique case (o)
      OP_SUB,
      OP_SBB:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // carry-in seen by the adder; for SBB cin=1 means no borrow
  function automatic logic op_cin(op_e o, logic c);
    logic r;
    r = 1'b0;
    unique case (o)
      OP_ADD:  r = 1'b0;
      OP_SUB:  r = 1'b1;
      default: r = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cs_block.sv
// Carry-select block: both candidate sums plus block generate/propagate.
// Ports: a, b operands; sum0/sum1 for carry-in 0/1; g, p block G/P.
module cs_block #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum0,
  output logic [W-1:0] sum1,
  output logic         g,
  output logic         p
);

  logic [W:0] s0;
  logic [W:0] s1;

  assign s0   = {1'b0, a} + {1'b0, b};
  assign s1   = s0 + {{W{1'b0}}, 1'b1};
  assign sum0 = s0[W-1:0];
  assign sum1 = s1[W-1:0];
  assign g    = s0[W];
  // all bits propagate: block sum is all ones, so cin passes through
  assign p    = &(a ^ b);

endmodule

// File: rtl/parallel_prefix_tree.sv
// Kogge-Stone prefix over block G/P with the global carry-in as entry 0.
// Ports: g, p per block; cin; c[i] carry into block i, c[NB] final carry.
module parallel_prefix_tree #(
  parameter int NB = 4
) (
  input  logic [NB-1:0] g,
  input  logic [NB-1:0] p,
  input  logic          cin,
  output logic [NB:0]   c
);

  localparam int N = NB + 1;
  localparam int L = $clog2(N);

  logic [N-1:0] gt;
  logic [N-1:0] pt;
  logic [N-1:0] gn;
  logic [N-1:0] pn;

  // entry 0 acts as a pure-generate block holding cin,
  // so prefix entry i is the carry into block i
  always_comb begin
    gt = {g, cin};
    pt = {p, 1'b0};
    gn = gt;
    pn = pt;
    for (int lv = 0; lv < L; lv++) begin
      gn = gt;
      pn = pt;
      for (int i = 0; i < N; i++) begin
        if (i >= (1 << lv)) begin
          gn[i] = gt[i] | (pt[i] & gt[i-(1<<lv)]);
          pn[i] = pt[i] & pt[i-(1<<lv)];
        end
      end
      gt = gn;
      pt = pn;
    end
    c = gt;
  end

endmodule

// File: rtl/pipelined_addsub_stream.sv
// Three-stage carry-select add/sub with valid/ready stream and tag sideband.
// Ports: clk, rst_n; v_in/rdy_in/op/a/b/cin/tag_in; v_out/rdy_out/sum/cout/ovf/zero/tag_out.
module pipelined_addsub_stream
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             v_in,
  output logic             rdy_in,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [TAG_W-1:0] tag_in,
  output logic             v_out,
  input  logic             rdy_out,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] tag_out
);

  localparam int NB = WIDTH / BLOCK;

  // whole pipe moves as one; only the output reg gates it
  logic en;
  assign en     = !v_out || rdy_out;
  assign rdy_in = en;

  // ---- S1: operand prep and per-block sums ----
  op_e             op_s;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH-1:0] bs0;
  logic [WIDTH-1:0] bs1;
  logic [NB-1:0]    bg;
  logic [NB-1:0]    bp;

  assign op_s  = op_e'(op);
  assign b_eff = op_inv(op_s) ? ~b : b;
  assign c_eff = op_cin(op_s, cin);

  for (genvar i = 0; i < NB; i++) begin : g_blk
    cs_block #(
      .W(BLOCK)
    ) u_cs (
      .a    (a[i*BLOCK +: BLOCK]),
      .b    (b_eff[i*BLOCK +: BLOCK]),
      .sum0 (bs0[i*BLOCK +: BLOCK]),
      .sum1 (bs1[i*BLOCK +: BLOCK]),
      .g    (bg[i]),
      .p    (bp[i])
    );
  end

  logic             s1_v;
  logic [WIDTH-1:0] s1_sum0;
  logic [WIDTH-1:0] s1_sum1;
  logic [NB-1:0]    s1_g;
  logic [NB-1:0]    s1_p;
  logic             s1_cin;
  logic             s1_am;
  logic             s1_bm;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_sum0 <= '0;
      s1_sum1 <= '0;
      s1_g    <= '0;
      s1_p    <= '0;
      s1_cin  <= 1'b0;
      s1_am   <= 1'b0;
      s1_bm   <= 1'b0;
      s1_tag  <= '0;
    end else if (en) begin
      s1_v    <= v_in;
      s1_sum0 <= bs0;
      s1_sum1 <= bs1;
      s1_g    <= bg;
      s1_p    <= bp;
      s1_cin  <= c_eff;
      s1_am   <= a[WIDTH-1];
      s1_bm   <= b_eff[WIDTH-1];
      s1_tag  <= tag_in;
    end
  end

  // ---- S2: block carries ----
  logic [NB:0] bc;

  parallel_prefix_tree #(
    .NB(NB)
  ) u_tree (
    .g   (s1_g),
    .p   (s1_p),
    .cin (s1_cin),
    .c   (bc)
  );

  logic             s2_v;
  logic [WIDTH-1:0] s2_sum0;
  logic [WIDTH-1:0] s2_sum1;
  logic [NB:0]      s2_c;
  logic             s2_am;
  logic             s2_bm;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_v    <= 1'b0;
      s2_sum0 <= '0;
      s2_sum1 <= '0;
      s2_c    <= '0;
      s2_am   <= 1'b0;
      s2_bm   <= 1'b0;
      s2_tag  <= '0;
    end else if (en) begin
      s2_v    <= s1_v;
      s2_sum0 <= s1_sum0;
      s2_sum1 <= s1_sum1;
      s2_c    <= bc;
      s2_am   <= s1_am;
      s2_bm   <= s1_bm;
      s2_tag  <= s1_tag;
    end
  end

  // ---- S3: select and flags ----
  logic [WIDTH-1:0] sel;

  for (genvar i = 0; i < NB; i++) begin : g_sel
    assign sel[i*BLOCK +: BLOCK] = s2_c[i]
      ? s2_sum1[i*BLOCK +: BLOCK]
      : s2_sum0[i*BLOCK +: BLOCK];
  end

  logic ovf_n;
  assign ovf_n = (s2_am == s2_bm) && (sel[WIDTH-1] != s2_am);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_out   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      tag_out <= '0;
    end else if (en) begin
      v_out   <= s2_v;
      sum     <= sel;
      cout    <= s2_c[NB];
      ovf     <= ovf_n;
      zero    <= ~|sel;
      tag_out <= s2_tag;
    end
  end

endmodule

// File: tb/tb_pipelined_addsub_stream.sv
// Directed testbench for pipelined_addsub_stream (WIDTH=32, BLOCK=8).
// Linear steps; immediate assertions; one summary line at the end.
module tb_pipelined_addsub_stream;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v_in;
  logic        rdy_in;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [3:0]  tag_in;
  logic        v_out;
  logic        rdy_out;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic [3:0]  tag_out;

  int total = 0;
  int bad   = 0;

  pipelined_addsub_stream #(
    .WIDTH(32),
    .BLOCK(8),
    .TAG_W(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .v_in    (v_in),
    .rdy_in  (rdy_in),
    .op      (op),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .tag_in  (tag_in),
    .v_out   (v_out),
    .rdy_out (rdy_out),
    .sum     (sum),
    .cout    (cout),
    .ovf     (ovf),
    .zero    (zero),
    .tag_out (tag_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string nm, logic [63:0] o, logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", nm, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic one(string nm, op_e o, logic [31:0] x, logic [31:0] y,
                     logic c, logic [3:0] t, logic [31:0] es,
                     logic ec, logic eo, logic ez);
    v_in = 1'b1; op = o; a = x; b = y; cin = c; tag_in = t;
    rdy_out = 1'b1;
    #1;
    chk({nm, ".rdy"}, 64'(rdy_in), 64'd1);
    step();
    v_in = 1'b0;
    chk({nm, ".lat1"}, 64'(v_out), 64'd0);
    step();
    chk({nm, ".lat2"}, 64'(v_out), 64'd0);
    step();
    chk({nm, ".v"}, 64'(v_out), 64'd1);
    chk({nm, ".sum"}, 64'(sum), 64'(es));
    chk({nm, ".cout"}, 64'(cout), 64'(ec));
    chk({nm, ".ovf"}, 64'(ovf), 64'(eo));
    chk({nm, ".zero"}, 64'(zero), 64'(ez));
    chk({nm, ".tag"}, 64'(tag_out), 64'(t));
    step();
    chk({nm, ".once"}, 64'(v_out), 64'd0);
  endtask

  int          k;
  int          first;
  int          last;
  int          issued;
  logic        acc;
  logic [31:0] ea;

  initial begin
    rst_n = 1'b0; v_in = 1'b0; op = 2'b00; a = '0; b = '0;
    cin = 1'b0; tag_in = '0; rdy_out = 1'b0;
    step();
    step();
    chk("rst.v_out", 64'(v_out), 64'd0);
    chk("rst.sum", 64'(sum), 64'd0);
    chk("rst.flags", 64'({cout, ovf, zero}), 64'd0);
    chk("rst.tag", 64'(tag_out), 64'd0);
    chk("rst.rdy_in", 64'(rdy_in), 64'd1);
    rst_n = 1'b1;
    step();

    one("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 4'h1,
        32'h0, 1'b1, 1'b0, 1'b1);
    one("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'h2,
        32'h8000_0000, 1'b0, 1'b1, 1'b0);
    one("sub_brw", OP_SUB, 32'h5, 32'h7, 1'b0, 4'h3,
        32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    one("sbb_zero", OP_SBB, 32'h0, 32'h0, 1'b0, 4'h4,
        32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    one("adc_blk", OP_ADC, 32'h0000_00FF, 32'h1, 1'b1, 4'h5,
        32'h0000_0101, 1'b0, 1'b0, 1'b0);
    one("sub_ovf", OP_SUB, 32'h8000_0000, 32'h1, 1'b0, 4'h6,
        32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    one("sub_eq", OP_SUB, 32'h7, 32'h7, 1'b1, 4'h7,
        32'h0, 1'b1, 1'b0, 1'b1);
    one("adc_ripple", OP_ADC, 32'h0000_FFFF, 32'hFFFF_0000, 1'b1, 4'h8,
        32'h0, 1'b1, 1'b0, 1'b1);
    one("sbb_nb", OP_SBB, 32'h10, 32'h3, 1'b1, 4'h9,
        32'hD, 1'b1, 1'b0, 1'b0);

    // back-to-back ADC stream, tags 0..7
    k = 0; first = -1; last = -1;
    rdy_out = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) begin
        v_in = 1'b1; op = OP_ADC; a = 32'(c); b = 32'd100;
        cin = 1'(c % 2); tag_in = 4'(c);
      end else begin
        v_in = 1'b0;
      end
      step();
      if (v_out) begin
        chk("b2b.tag", 64'(tag_out), 64'(k));
        chk("b2b.sum", 64'(sum), 64'(100 + k + (k % 2)));
        if (first < 0) first = c;
        last = c;
        k++;
      end
    end
    chk("b2b.count", 64'(k), 64'd8);
    chk("b2b.contig", 64'(last - first), 64'd7);
    chk("b2b.first", 64'(first), 64'd2);

    // stall with a full pipe, then drain
    k = 0; issued = 0;
    for (int c = 0; c < 40 && k < 6; c++) begin
      rdy_out = !(c >= 3 && c < 8);
      v_in = (issued < 6);
      op = OP_ADD;
      a = 32'((issued << 24) | issued);
      b = 32'h00FF_00FF;
      cin = 1'b0;
      tag_in = 4'(8 + issued);
      #1;
      if (c >= 3 && c < 8) begin
        chk("stall.rdy_in", 64'(rdy_in), 64'd0);
        chk("stall.v_out", 64'(v_out), 64'd1);
      end
      if (v_out) begin
        ea = 32'((k << 24) | k);
        chk("stall.tag", 64'(tag_out), 64'(8 + k));
        chk("stall.sum", 64'(sum), 64'(ea + 32'h00FF_00FF));
        if (rdy_out) k++;
      end
      acc = v_in && rdy_in;
      step();
      if (acc) issued++;
    end
    chk("stall.drained", 64'(k), 64'd6);
    v_in = 1'b0;
    rdy_out = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("stall.nodup", 64'(v_out), 64'd0);
    end

    // reset with three operations in flight
    v_in = 1'b1; op = OP_ADD; a = 32'h11; b = 32'h22; tag_in = 4'h1;
    step();
    a = 32'h33; tag_in = 4'h2;
    step();
    a = 32'h44; tag_in = 4'h3;
    rst_n = 1'b0;
    step();
    v_in = 1'b0;
    chk("mrst.v_out", 64'(v_out), 64'd0);
    chk("mrst.sum", 64'(sum), 64'd0);
    chk("mrst.flags", 64'({cout, ovf, zero}), 64'd0);
    chk("mrst.tag", 64'(tag_out), 64'd0);
    chk("mrst.rdy_in", 64'(rdy_in), 64'd1);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("mrst.gone", 64'(v_out), 64'd0);
    end

    one("post_rst", OP_ADD, 32'h3, 32'h4, 1'b0, 4'hA,
        32'h7, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub_stream.md
PIPELINED_ADDSUB_STREAM -- requirements
Module: pipelined_addsub_stream

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter BLOCK, default 8: carry-select block width; WIDTH SHALL be a multiple of BLOCK and WIDTH/BLOCK SHALL be >= 2.
REQ-003 Parameter TAG_W, default 4: width of the sideband tag carried alongside each operation.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 v_in  input  1  input operation valid.
REQ-007 rdy_in  output  1  block can accept an operation this cycle.
REQ-008 op  input  2  operation select: 00 ADD, 01 SUB, 10 ADC, 11 SBB.
REQ-009 a, b  input  WIDTH each  operands.
REQ-010 cin  input  1  carry/borrow-in, used only by ADC and SBB.
REQ-011 tag_in  input  TAG_W  sideband tag.
REQ-012 v_out  output  1  result valid.
REQ-013 rdy_out  input  1  downstream accepts the result this cycle.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  carry out of the MSB (raw; for SUB/SBB, 1 means no borrow).
REQ-016 ovf  output  1  two's-complement signed overflow.
REQ-017 zero  output  1  sum == 0.
REQ-018 tag_out  output  TAG_W  tag of the operation that produced the result.

Function
REQ-019 Effective operand: b_eff = b for ADD/ADC and ~b for SUB/SBB.
REQ-020 Effective carry-in: 0 for ADD, 1 for SUB, cin for ADC, and cin for SBB (cin=1 means no borrow).
REQ-021 The result SHALL be sum = (a + b_eff + c_eff) mod 2^WIDTH, with cout equal to bit WIDTH of that sum.
REQ-022 ovf SHALL equal (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
REQ-023 The datapath SHALL have three stages: S1 computes block sums and block G/P; S2 runs the prefix carry tree; S3 applies the block mux and computes flags.
REQ-024 Latency SHALL be exactly 3 cycles from an accepted input (v_in && rdy_in) to v_out when no stall occurs.
REQ-025 Advance enable: en = !v_out || rdy_out; rdy_in SHALL equal en, with no combinational path from v_in to rdy_in.
REQ-026 When en=0, all stage registers, valid bits, v_out, sum, flags and tag_out SHALL hold their values.
REQ-027 When en=1, each valid bit SHALL shift forward and empty stages (bubbles) SHALL propagate.
REQ-028 Data registers MAY load when their incoming valid bit is 0; consumers SHALL only qualify data with v_out.
REQ-029 Throughput SHALL be one operation per cycle while rdy_out=1.
REQ-030 The output SHALL be stable while v_out=1 and rdy_out=0.
REQ-031 Operations SHALL emerge in acceptance order, each with its own tag, and none SHALL be dropped or duplicated.

Reset
REQ-032 While rst_n=0 at a clock edge, all stage valid bits and v_out SHALL clear to 0.
REQ-033 While rst_n=0 at a clock edge, sum, cout, ovf, zero and tag_out SHALL clear to 0.
REQ-034 During reset rdy_in SHALL read 1, because it follows en = !v_out.
REQ-035 Any operation in flight when reset is asserted SHALL be discarded.
REQ-036 The first input after rst_n rises SHALL be accepted with normal latency.

Structure
REQ-037 Op encodings (OP_ADD, OP_SUB, OP_ADC, OP_SBB) SHALL be defined in the shared alu_pkg constants file.
REQ-038 Stage count 3 SHALL be defined in alu_pkg as constant ADDSUB_LAT.
REQ-039 Per-block sum0/sum1/G/P generation SHALL reuse the existing cs_block sub-module.
REQ-040 Block carries SHALL come from the existing parallel_prefix_tree.
REQ-041 No new sub-module SHALL be introduced.

Verification (WIDTH=32, BLOCK=8)
REQ-042 ADD a=0xFFFFFFFF, b=0x00000001 -> 3 cycles later: sum=0, cout=1, ovf=0, zero=1.
REQ-043 ADD a=0x7FFFFFFF, b=1 -> sum=0x80000000, cout=0, ovf=1, zero=0.
REQ-044 SUB a=5, b=7 -> sum=0xFFFFFFFE, cout=0 (borrow), ovf=0; SBB a=0, b=0, cin=0 -> sum=0xFFFFFFFF, cout=0.
REQ-045 Back-to-back: 8 ADC operations with tags 0..7 and rdy_out=1 -> 8 consecutive v_out cycles with tags 0..7 in order.
REQ-046 Stall: hold rdy_out=0 for 5 cycles while the pipeline is full -> rdy_in=0, outputs frozen; on release results drain in order with no loss.
REQ-047 Reset mid-stream: assert rst_n=0 with 3 operations in flight -> next cycle v_out=0 and outputs cleared; none of the 3 results ever appears.
